// File: rtl/spike_reader_pkg.sv
// spike_reader_pkg: FSM states and Wishbone constants shared by the spike-out reader.
package spike_reader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        OUT  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [31:0] SPIKE_OUT_BASE = 32'h3000_8000;
    localparam logic [3:0]  WB_SEL_ALL     = 4'b1111;

endpackage

// File: rtl/spike_out_reader.sv
// spike_out_reader: reads up to MAX_WORDS spike-out words from neuron_core over a
// Wishbone read-only initiator and forwards each one on a valid/ready stream.
// Optional ack timeout is enabled by defining SPIKE_READER_TIMEOUT_EN; without it
// a read waits for its ack indefinitely and err_o is tied low.
module spike_out_reader
    import spike_reader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = SPIKE_OUT_BASE,
    parameter int          MAX_WORDS   = 8,
    parameter int          TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [7:0]  num_words_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        spk_valid_o,
    output logic [31:0] spk_data_o,
    output logic [7:0]  spk_idx_o,
    input  logic        spk_ready_i
);

    localparam logic [7:0] MAX_N = 8'(MAX_WORDS);

    state_t      r_state;
    logic [7:0]  r_n;
    logic [7:0]  r_k;
    logic        r_cyc;
    logic        r_done;
    logic        r_valid;
    logic [31:0] r_data;
    logic [7:0]  r_idx;
    logic [31:0] r_adr;

    logic [7:0]  w_n;
    logic [7:0]  w_kNext;
    logic [31:0] w_nextAdr;
    logic        w_ack;

    // Job length is clamped so a large request can never run past the spike-out window.
    assign w_n       = (num_words_i > MAX_N) ? MAX_N : num_words_i;
    assign w_kNext   = r_k + 8'd1;
    assign w_nextAdr = BASE_ADDR + {22'd0, w_kNext, 2'b00};
    // A stray ack outside an open bus cycle must never advance the FSM.
    assign w_ack     = wbm_ack_i & r_cyc;

`ifdef SPIKE_READER_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    logic [15:0] r_tmo;
    logic        r_err;

    assign err_o = r_err;
`else
    logic [31:0] w_unused_timeout;

    assign w_unused_timeout = 32'(TIMEOUT_CYC);
    assign err_o            = 1'b0;
`endif

    assign busy_o      = (r_state != IDLE);
    assign done_o      = r_done;
    assign wbm_cyc_o   = r_cyc;
    assign wbm_stb_o   = r_cyc;
    assign wbm_we_o    = 1'b0;
    assign wbm_sel_o   = WB_SEL_ALL;
    assign wbm_adr_o   = r_adr;
    assign spk_valid_o = r_valid;
    assign spk_data_o  = r_data;
    assign spk_idx_o   = r_idx;

    // Job sequencer: one bus read per word, then hold the word on the stream until taken.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_n     <= 8'd0;
            r_k     <= 8'd0;
            r_cyc   <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= 32'd0;
            r_idx   <= 8'd0;
            r_adr   <= 32'd0;
`ifdef SPIKE_READER_TIMEOUT_EN
            r_tmo   <= 16'd0;
            r_err   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_n <= w_n;
                        r_k <= 8'd0;
`ifdef SPIKE_READER_TIMEOUT_EN
                        r_err <= 1'b0;
                        r_tmo <= 16'd0;
`endif
                        if (w_n == 8'd0) begin
                            r_state <= DONE;
                        end else begin
                            r_state <= READ;
                            r_cyc   <= 1'b1;
                            r_adr   <= BASE_ADDR;
                        end
                    end
                end
                READ: begin
                    if (w_ack) begin
                        r_data  <= wbm_dat_i;
                        r_idx   <= r_k;
                        r_cyc   <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= OUT;
                    end
`ifdef SPIKE_READER_TIMEOUT_EN
                    else if (r_tmo == TMO_LAST) begin
                        r_cyc   <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_tmo <= r_tmo + 16'd1;
                    end
`endif
                end
                OUT: begin
                    if (spk_ready_i) begin
                        r_valid <= 1'b0;
                        r_k     <= w_kNext;
                        if (w_kNext < r_n) begin
                            r_state <= READ;
                            r_cyc   <= 1'b1;
                            r_adr   <= w_nextAdr;
`ifdef SPIKE_READER_TIMEOUT_EN
                            r_tmo   <= 16'd0;
`endif
                        end else begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_out_reader.sv
// tb_spike_out_reader: scoreboard bench for spike_out_reader. Stimulus pushes the
// expected bus addresses, stream words and done/err outcomes into queues; a Wishbone
// responder, a stream monitor and a done monitor pop and compare independently.
// The timeout scenario is exercised when SPIKE_READER_TIMEOUT_EN is defined.
module tb_spike_out_reader;

    localparam int MAX_WORDS   = 8;
    localparam int TIMEOUT_CYC = 16;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [7:0]  num_words_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        spk_valid_o;
    logic [31:0] spk_data_o;
    logic [7:0]  spk_idx_o;
    logic        spk_ready_i;

    int checks = 0;
    int errors = 0;

    logic [31:0] expAdrQ[$];
    logic [39:0] expStreamQ[$];
    logic        expDoneQ[$];

    int   ackDelay     = 1;
    bit   ackEnable    = 1'b1;
    bit   strayAck     = 1'b0;
    int   waitCnt      = 0;
    int   readCount    = 0;
    int   cycCycles    = 0;
    int   validCycles  = 0;
    int   busDuringOut = 0;
    int   doneCount    = 0;
    logic [31:0] lastAdr  = 32'd0;
    logic [31:0] holdAdr  = 32'd0;
    logic        prevDone = 1'b0;

    spike_out_reader #(
        .BASE_ADDR   (32'h3000_8000),
        .MAX_WORDS   (MAX_WORDS),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .num_words_i (num_words_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_ack_i   (wbm_ack_i),
        .spk_valid_o (spk_valid_o),
        .spk_data_o  (spk_data_o),
        .spk_idx_o   (spk_idx_o),
        .spk_ready_i (spk_ready_i)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something wedges the whole run.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: run exceeded time limit, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    // Responder memory contents: upper half is the low address half, lower half its inverse.
    function automatic logic [31:0] memData(input logic [31:0] adr);
        return {adr[15:0], ~adr[15:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] nWords);
        num_words_i = nWords;
        start_i     = 1'b1;
        tick();
        start_i     = 1'b0;
    endtask

    task automatic expectJob(input int nEff, input logic expErr, input bit withStream);
        for (int i = 0; i < nEff; i++) begin
            logic [31:0] adr;
            adr = 32'h3000_8000 + 32'(4 * i);
            expAdrQ.push_back(adr);
            if (withStream) expStreamQ.push_back({8'(i), memData(adr)});
        end
        expDoneQ.push_back(expErr);
    endtask

    task automatic waitJob(input string name, input int budget);
        int startCount;
        int n;
        startCount = doneCount;
        n = 0;
        while (doneCount == startCount && n < budget) begin
            tick();
            n++;
        end
        checkOutput(name, 64'(doneCount - startCount), 64'd1);
        tick();
    endtask

    // Wishbone responder: checks each new read address and acks after ackDelay cycles.
    initial begin
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'd0;
        forever begin
            @(negedge clk);
            if (rst && wbm_cyc_o) begin
                if (waitCnt == 0) begin
                    readCount++;
                    lastAdr = wbm_adr_o;
                    holdAdr = wbm_adr_o;
                    if (expAdrQ.size() == 0) checkOutput("readPending", 64'(expAdrQ.size()), 64'd1);
                    else checkOutput("readAdr", 64'(wbm_adr_o), 64'(expAdrQ.pop_front()));
                    checkOutput("busCtrl", 64'({wbm_stb_o, wbm_we_o, wbm_sel_o}), 64'(6'b10_1111));
                end else begin
                    checkOutput("adrHold", 64'({wbm_stb_o, wbm_adr_o}), 64'({1'b1, holdAdr}));
                end
                cycCycles++;
                if (ackEnable && waitCnt >= ackDelay) begin
                    wbm_ack_i = 1'b1;
                    wbm_dat_i = memData(wbm_adr_o);
                end else begin
                    wbm_ack_i = 1'b0;
                    wbm_dat_i = 32'hDEAD_BEEF;
                end
                waitCnt++;
            end else begin
                wbm_ack_i = strayAck;
                wbm_dat_i = 32'hBAD0_0000;
                waitCnt   = 0;
            end
        end
    end

    // Stream monitor: every accepted word must match the head of the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && spk_valid_o) begin
                validCycles++;
                if (wbm_cyc_o) busDuringOut++;
                if (spk_ready_i) begin
                    if (expStreamQ.size() == 0) checkOutput("streamPending", 64'(expStreamQ.size()), 64'd1);
                    else checkOutput("streamWord", 64'({spk_idx_o, spk_data_o}), 64'(expStreamQ.pop_front()));
                end
            end
        end
    end

    // Done monitor: single-cycle pulse with the expected error flag.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && done_o) begin
                doneCount++;
                checkOutput("donePulseWidth", 64'(prevDone), 64'd0);
                if (expDoneQ.size() == 0) checkOutput("donePending", 64'(expDoneQ.size()), 64'd1);
                else checkOutput("errAtDone", 64'(err_o), 64'(expDoneQ.pop_front()));
            end
            prevDone = rst && done_o;
        end
    end

    // Directed scenarios.
    initial begin
        int r0;
        int c0;
        int v0;
        int n;

        rst         = 1'b0;
        start_i     = 1'b0;
        num_words_i = 8'd0;
        spk_ready_i = 1'b1;
        repeat (3) tick();
        checkOutput("resetCtrl", 64'({busy_o, done_o, err_o, wbm_cyc_o, wbm_stb_o, spk_valid_o}), 64'd0);
        checkOutput("resetData", 64'({spk_idx_o, spk_data_o}), 64'd0);
        checkOutput("resetAdr", 64'(wbm_adr_o), 64'd0);
        rst = 1'b1;
        tick();

        // Three words, ack one cycle after stb, stream always ready.
        ackDelay = 1;
        expAdrQ.push_back(32'h3000_8000);
        expAdrQ.push_back(32'h3000_8004);
        expAdrQ.push_back(32'h3000_8008);
        expStreamQ.push_back({8'd0, 32'h8000_7FFF});
        expStreamQ.push_back({8'd1, 32'h8004_7FFB});
        expStreamQ.push_back({8'd2, 32'h8008_7FF7});
        expDoneQ.push_back(1'b0);
        r0 = readCount;
        applyStimulus(8'd3);
        checkOutput("busyAfterStart", 64'(busy_o), 64'd1);
        waitJob("job3Done", 40);
        checkOutput("job3Reads", 64'(readCount - r0), 64'd3);
        checkOutput("job3Err", 64'(err_o), 64'd0);

        // Two words with the consumer stalling five cycles on word 0.
        spk_ready_i = 1'b0;
        expectJob(2, 1'b0, 1'b1);
        applyStimulus(8'd2);
        n = 0;
        while (!spk_valid_o && n < 20) begin
            tick();
            n++;
        end
        checkOutput("stallValidSeen", 64'(spk_valid_o), 64'd1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("stallData", 64'({spk_idx_o, spk_data_o}), 64'({8'd0, 32'h8000_7FFF}));
            checkOutput("stallNoBus", 64'(wbm_cyc_o), 64'd0);
            tick();
        end
        spk_ready_i = 1'b1;
        tick();
        checkOutput("secondReadStart", 64'({wbm_cyc_o, wbm_adr_o}), 64'({1'b1, 32'h3000_8004}));
        waitJob("stallDone", 40);

        // Oversized request is clamped to MAX_WORDS, with same-cycle acks.
        ackDelay = 0;
        expectJob(8, 1'b0, 1'b1);
        r0 = readCount;
        c0 = cycCycles;
        applyStimulus(8'd20);
        waitJob("clampDone", 60);
        checkOutput("clampReads", 64'(readCount - r0), 64'd8);
        checkOutput("clampLastAdr", 64'(lastAdr), 64'h3000_801C);
        checkOutput("clampCycCycles", 64'(cycCycles - c0), 64'd8);

        // Zero-length job, with stray acks while no bus cycle is open.
        strayAck = 1'b1;
        c0 = cycCycles;
        v0 = validCycles;
        expDoneQ.push_back(1'b0);
        applyStimulus(8'd0);
        checkOutput("zeroDoneCycle1", 64'({done_o, busy_o}), 64'd1);
        tick();
        checkOutput("zeroDoneCycle2", 64'({done_o, busy_o}), 64'd2);
        tick();
        tick();
        strayAck = 1'b0;
        checkOutput("zeroNoBus", 64'(cycCycles - c0), 64'd0);
        checkOutput("zeroNoValid", 64'(validCycles - v0), 64'd0);

`ifdef SPIKE_READER_TIMEOUT_EN
        // Responder never acks: read aborts after TIMEOUT_CYC cycles with err set.
        ackEnable = 1'b0;
        expectJob(1, 1'b1, 1'b0);
        c0 = cycCycles;
        v0 = validCycles;
        applyStimulus(8'd1);
        waitJob("timeoutDone", 60);
        checkOutput("timeoutCycCycles", 64'(cycCycles - c0), 64'(TIMEOUT_CYC));
        checkOutput("timeoutErr", 64'({err_o, wbm_cyc_o}), 64'd2);
        checkOutput("timeoutNoValid", 64'(validCycles - v0), 64'd0);
        ackEnable = 1'b1;
        ackDelay  = 0;
        expectJob(1, 1'b0, 1'b1);
        applyStimulus(8'd1);
        checkOutput("errClearedOnStart", 64'(err_o), 64'd0);
        waitJob("afterTimeoutDone", 40);
`else
        // Slow responder: the read simply waits for its ack.
        ackDelay = 20;
        expectJob(1, 1'b0, 1'b1);
        c0 = cycCycles;
        applyStimulus(8'd1);
        waitJob("longWaitDone", 60);
        checkOutput("longWaitCycCycles", 64'(cycCycles - c0), 64'd21);
        checkOutput("longWaitErr", 64'(err_o), 64'd0);
`endif

        // A start pulse while busy must not restart or resize the job.
        ackDelay = 3;
        expectJob(2, 1'b0, 1'b1);
        r0 = readCount;
        applyStimulus(8'd2);
        num_words_i = 8'd5;
        start_i     = 1'b1;
        tick();
        tick();
        start_i = 1'b0;
        waitJob("ignoreStartDone", 60);
        checkOutput("ignoreStartReads", 64'(readCount - r0), 64'd2);

        // Reset in the middle of a bus cycle abandons the job.
        ackDelay = 5;
        expectJob(3, 1'b0, 1'b1);
        applyStimulus(8'd3);
        tick();
        checkOutput("preResetCyc", 64'(wbm_cyc_o), 64'd1);
        rst = 1'b0;
        tick();
        checkOutput("midResetCtrl", 64'({busy_o, done_o, err_o, wbm_cyc_o, wbm_stb_o, spk_valid_o}), 64'd0);
        checkOutput("midResetData", 64'({spk_idx_o, spk_data_o}), 64'd0);
        checkOutput("midResetAdr", 64'(wbm_adr_o), 64'd0);
        expAdrQ.delete();
        expStreamQ.delete();
        expDoneQ.delete();
        tick();
        rst = 1'b1;
        tick();
        tick();
        checkOutput("postResetIdle", 64'({busy_o, wbm_cyc_o, spk_valid_o}), 64'd0);

        // The block recovers cleanly after the abandoned job.
        ackDelay = 0;
        expectJob(1, 1'b0, 1'b1);
        applyStimulus(8'd1);
        waitJob("recoveryDone", 40);

        checkOutput("adrQueueDrained", 64'(expAdrQ.size()), 64'd0);
        checkOutput("streamQueueDrained", 64'(expStreamQ.size()), 64'd0);
        checkOutput("doneQueueDrained", 64'(expDoneQ.size()), 64'd0);
        checkOutput("busDuringOut", 64'(busDuringOut), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spike_out_reader.md
SPIKE_OUT_READER -- requirements
Module: spike_out_reader

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h3000_8000, which is the byte address of spike-out word 0.
REQ-002 The block SHALL have parameter MAX_WORDS, default 8, which is the upper clamp on words read per job.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 16, which is the number of cycles allowed without ack before abort.
REQ-004 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-005 rst  in  1  reset; synchronous, active-low.
REQ-006 start_i  in  1  begin read job; sampled in IDLE only.
REQ-007 num_words_i  in  8  number of 32-bit words to read; captured at start.
REQ-008 busy_o  out  1  high whenever state is not IDLE.
REQ-009 done_o  out  1  one-cycle pulse at job end.
REQ-010 err_o  out  1  sticky timeout flag; cleared on next accepted start.
REQ-011 wbm_cyc_o / wbm_stb_o / wbm_we_o  out  1 each  Wishbone initiator controls; wbm_we_o SHALL be tied 0.
REQ-012 wbm_sel_o  out  4  SHALL be constant 4'b1111.
REQ-013 wbm_adr_o  out  32  read address.
REQ-014 wbm_dat_i  in  32  read data from neuron_core.
REQ-015 wbm_ack_i  in  1  responder acknowledge.
REQ-016 spk_valid_o / spk_data_o / spk_idx_o  out  1/32/8  output stream: valid flag, captured word, word index.
REQ-017 spk_ready_i  in  1  stream backpressure.

Function
REQ-018 The FSM SHALL use states IDLE, READ, OUT and DONE.
REQ-019 IDLE: on start_i=1, the block SHALL latch N=min(num_words_i, MAX_WORDS), set k=0 and clear err_o; it SHALL go to DONE if N=0, else to READ.
REQ-020 READ: the block SHALL assert cyc=stb=1 with adr=BASE_ADDR+4*k; it SHALL hold cyc, stb and adr stable until an ack is sampled.
REQ-021 When ack=1 is sampled in READ, the block SHALL capture wbm_dat_i into spk_data_o and k into spk_idx_o, deassert cyc/stb in the next cycle, and go to OUT.
REQ-022 An ack arriving while cyc or stb is low SHALL be ignored.
REQ-023 OUT: spk_valid_o SHALL be 1 and data SHALL be held stable until spk_ready_i=1.
REQ-024 On the OUT handshake, the block SHALL increment k and go to READ if k+1<N, else to DONE.
REQ-025 DONE: done_o SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-026 start_i SHALL be ignored in any state other than IDLE.
REQ-027 Minimum latency per word SHALL be 2 cycles (READ with same-cycle ack, then OUT with ready=1).
REQ-028 An N=0 job SHALL produce done_o 2 cycles after start with no bus activity.
REQ-029 k SHALL be 8 bits wide, and its address arithmetic SHALL be 32-bit with no wrap within the MAX_WORDS range.

Reset
REQ-030 When rst=0 at a clock edge, the FSM SHALL enter IDLE.
REQ-031 During reset, busy_o, done_o, err_o, cyc, stb, spk_valid_o and k SHALL be 0, and spk_data_o, spk_idx_o and wbm_adr_o SHALL be 0.
REQ-032 A reset asserted in the middle of a bus cycle SHALL drop cyc/stb in the same edge, and the job SHALL be abandoned.

Configuration
REQ-033 The ack timeout feature SHALL be controlled by macro SPIKE_READER_TIMEOUT_EN.
REQ-034 When SPIKE_READER_TIMEOUT_EN is defined: a counter SHALL clear on READ entry and increment each READ cycle without ack; on reaching TIMEOUT_CYC the block SHALL drop cyc/stb, set err_o=1 and go to DONE, and no stream word SHALL be emitted for that read.
REQ-035 When SPIKE_READER_TIMEOUT_EN is not defined: READ SHALL wait indefinitely, and err_o SHALL be tied 0.

Structure
REQ-036 Package spike_reader_pkg SHALL hold the FSM state enum, the SPIKE_OUT_BASE constant (32'h3000_8000) and the WB_SEL_ALL constant.
REQ-037 The block SHALL be a single module with no sub-module; the timeout counter SHALL be inline.

Verification
REQ-038 The bench SHALL cover: N=3, responder acks 1 cycle after stb, ready=1 -> reads at 0x30008000, 0x30008004 and 0x30008008; stream idx 0,1,2 with the responder data; one done pulse; err_o=0.
REQ-039 The bench SHALL cover: N=2, ready held low 5 cycles on word 0 -> spk_data_o stable; no bus cycle during the stall; second read starts the cycle after ready.
REQ-040 The bench SHALL cover: num_words_i=20 with MAX_WORDS=8 -> exactly 8 reads, with the last address 0x3000801C.
REQ-041 The bench SHALL cover: num_words_i=0 -> done_o 2 cycles after start, with cyc never asserted.
REQ-042 The bench SHALL cover, with SPIKE_READER_TIMEOUT_EN defined: no ack and TIMEOUT_CYC=16 -> cyc drops after 16 READ cycles, err_o=1, done pulses, no valid; the next start clears err_o.
REQ-043 The bench SHALL cover: start while busy and reset during READ -> start ignored; after reset, all outputs are 0 and the FSM is in IDLE.
